seq_alu: RTL

Parametrised, handshaked execution unit that supersedes the purely combinational ALU in the RISC-V datapath. Single-cycle logic/arithmetic/shift/compare operations complete in one cycle. Optional iterative unsigned multiply/divide takes XLEN cycles. Sits between operand fetch and writeback; a valid/ready pair on each side lets the pipeline stall on long operations.

---
 rtl/seq_alu_pkg.sv | 34 +++
 rtl/seq_alu_muldiv.sv | 72 +++++++
 rtl/seq_alu.sv | 130 +++++++++++++
 3 files changed

// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: operation codes, FSM states and the
// classifier that separates iterative mul/div ops from single-cycle ones.
package seq_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_OR    = 4'h2,
    OP_AND   = 4'h3,
    OP_XOR   = 4'h4,
    OP_SLT   = 4'h5,
    OP_SLTU  = 4'h6,
    OP_SLL   = 4'h7,
    OP_SRL   = 4'h8,
    OP_SRA   = 4'h9,
    OP_MUL   = 4'hA,
    OP_MULHU = 4'hB,
    OP_DIVU  = 4'hC,
    OP_REMU  = 4'hD,
    OP_RSV0  = 4'hE,
    OP_RSV1  = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_iterative(input alu_op_e op);
    return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned multiply/divide: shift-add multiplier and restoring
// divider sharing one 2*XLEN accumulator, one step per cycle for XLEN cycles.
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q;
  logic [CW-1:0]     cnt_q;
  logic              mul_q, hi_q, active_q;
  logic [XLEN:0]     sum, tmp;
  logic [XLEN-1:0]   diff;
  logic              ge;

  // Multiply keeps {partial product, multiplier}; divide keeps {remainder, dividend/quotient}.
  always_comb begin
    sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_q};
    tmp  = acc_q[2*XLEN-1:XLEN-1];
    ge   = (tmp >= {1'b0, b_q});
    diff = tmp[XLEN-1:0] - b_q;
    if (mul_q) begin
      acc_d = acc_q[0] ? {sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    end else begin
      acc_d = ge ? {diff, acc_q[XLEN-2:0], 1'b1} : {tmp[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      mul_q    <= 1'b0;
      hi_q     <= 1'b0;
      active_q <= 1'b0;
    end else if (clear) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start) begin
      acc_q    <= {{XLEN{1'b0}}, a};
      b_q      <= b;
      cnt_q    <= '0;
      mul_q    <= (op == OP_MUL) || (op == OP_MULHU);
      hi_q     <= (op == OP_MULHU) || (op == OP_REMU);
      active_q <= 1'b1;
    end else if (active_q) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + 1'b1;
      if (done) active_q <= 1'b0;
    end
  end

  // Result is taken from the final step's next value so the top can register it directly.
  assign done   = active_q && (cnt_q == CW'(XLEN - 1));
  assign result = hi_q ? acc_d[2*XLEN-1:XLEN] : acc_d[XLEN-1:0];

endmodule

// File: rtl/seq_alu.sv
// Handshaked execution unit: single-cycle ALU ops plus optional iterative
// mul/div enabled by the SEQ_ALU_MULDIV_EN macro.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            zero_flag,
  output logic            busy,
  output logic [1:0]      dbg_state
);

  localparam int SHW = $clog2(XLEN);

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic [XLEN-1:0] sc_result;
  logic [SHW-1:0]  shamt;
  logic            go_iter;
  logic            md_done;
  logic [XLEN-1:0] md_result;
  alu_op_e         op;

  assign op    = alu_op_e'(alu_control);
  assign shamt = in2[SHW-1:0];

  always_comb begin
    sc_result = '0;
    case (op)
      OP_ADD:  sc_result = in1 + in2;
      OP_SUB:  sc_result = in1 - in2;
      OP_OR:   sc_result = in1 | in2;
      OP_AND:  sc_result = in1 & in2;
      OP_XOR:  sc_result = in1 ^ in2;
      OP_SLT:  sc_result = {{(XLEN-1){1'b0}}, ($signed(in1) < $signed(in2))};
      OP_SLTU: sc_result = {{(XLEN-1){1'b0}}, (in1 < in2)};
      OP_SLL:  sc_result = in1 << shamt;
      OP_SRL:  sc_result = in1 >> shamt;
      OP_SRA:  sc_result = $signed(in1) >>> shamt;
      default: sc_result = '0;
    endcase
  end

`ifdef SEQ_ALU_MULDIV_EN
  assign go_iter = (state_q == S_IDLE) && in_valid && !flush && is_iterative(op);

  seq_alu_muldiv #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .clear  (flush),
    .start  (go_iter),
    .op     (alu_control),
    .a      (in1),
    .b      (in2),
    .done   (md_done),
    .result (md_result)
  );
  assign busy = (state_q == S_BUSY);
`else
  assign go_iter   = 1'b0;
  assign md_done   = 1'b0;
  assign md_result = '0;
  assign busy      = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (go_iter) begin
            state_d = S_BUSY;
          end else begin
            state_d  = S_DONE;
            result_d = sc_result;
            zero_d   = (sc_result == '0);
          end
        end
      end
      S_BUSY: begin
        if (md_done) begin
          state_d  = S_DONE;
          result_d = md_result;
          zero_d   = (md_result == '0);
        end
      end
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort wins over any handshake in the same cycle; the held result is simply invalidated.
    if (flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
      zero_d   = zero_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign alu_result = result_q;
  assign zero_flag  = zero_q;
  assign dbg_state  = state_q;

endmodule
